ex_mem_skid_reg: RTL and testbench



---
 rtl/ex_mem_skid_reg.sv | 142 ++++++++++++++
 tb/tb_ex_mem_skid_reg.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/ex_mem_skid_reg.sv
// EX->MEM result register: two-entry skid buffer (main + skid).
// in_ready is a flop so MEM back-pressure never reaches EX combinationally.
module ex_mem_skid_reg #(
  parameter int XLEN = 32,
  parameter int RD_W = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_alu_result,
  input  logic            in_alu_zero,
  input  logic [XLEN-1:0] in_store_data,
  input  logic [RD_W-1:0] in_rd,
  input  logic            in_wb_en,
  input  logic            in_mem_rd,
  input  logic            in_mem_wr,
  input  logic [2:0]      in_funct3,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_alu_result,
  output logic            out_alu_zero,
  output logic [XLEN-1:0] out_store_data,
  output logic [RD_W-1:0] out_rd,
  output logic            out_wb_en,
  output logic            out_mem_rd,
  output logic            out_mem_wr,
  output logic [2:0]      out_funct3,
  output logic [1:0]      occupancy
);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] res;
    logic            zero;
    logic [XLEN-1:0] sd;
    logic [RD_W-1:0] rd;
    logic            wb_en;
    logic            mem_rd;
    logic            mem_wr;
    logic [2:0]      funct3;
  } pay_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t state_q, state_d;
  pay_t   main_q, main_d;
  pay_t   skid_q, skid_d;
  logic   rdy_q, rdy_d;
  pay_t   in_pay;
  logic   accept;
  logic   take;

  assign in_pay = '{
    pc:     in_pc,
    res:    in_alu_result,
    zero:   in_alu_zero,
    sd:     in_store_data,
    rd:     in_rd,
    wb_en:  in_wb_en,
    mem_rd: in_mem_rd,
    mem_wr: in_mem_wr,
    funct3: in_funct3
  };

  assign accept = in_valid & rdy_q;
  assign take   = (state_q != EMPTY) & out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    unique case (state_q)
      EMPTY: begin
        if (accept) begin
          main_d  = in_pay;
          state_d = BUSY;
        end
      end
      BUSY: begin
        unique case (1'b1)
          accept & take:  main_d = in_pay;
          accept & !take: begin
            skid_d  = in_pay;
            state_d = FULL;
          end
          !accept & take: state_d = EMPTY;
          default:        state_d = BUSY;
        endcase
      end
      FULL: begin
        if (take) begin
          main_d  = skid_q;
          state_d = BUSY;
        end
      end
      default: state_d = EMPTY;
    endcase
    // flush wins over any accept/take; payload may stay stale
    if (flush) begin
      state_d = EMPTY;
      main_d  = main_q;
      skid_d  = skid_q;
    end
    rdy_d = (state_d != FULL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      rdy_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      rdy_q   <= rdy_d;
    end
  end

  assign in_ready       = rdy_q;
  assign out_valid      = (state_q != EMPTY);
  assign occupancy      = state_q;
  assign out_pc         = main_q.pc;
  assign out_alu_result = main_q.res;
  assign out_alu_zero   = main_q.zero;
  assign out_store_data = main_q.sd;
  assign out_rd         = main_q.rd;
  assign out_wb_en      = main_q.wb_en;
  assign out_mem_rd     = main_q.mem_rd;
  assign out_mem_wr     = main_q.mem_wr;
  assign out_funct3     = main_q.funct3;

endmodule

// File: tb/tb_ex_mem_skid_reg.sv
// Bench for ex_mem_skid_reg: directed scenarios, then random
// valid/ready/flush traffic against a queue-based FIFO model.
module tb_ex_mem_skid_reg;

  localparam int XLEN = 32;
  localparam int RD_W = 5;
  localparam int PW   = 3*XLEN + RD_W + 7;

  typedef logic [PW-1:0] pay_t;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            flush = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [XLEN-1:0] in_pc = '0;
  logic [XLEN-1:0] in_alu_result = '0;
  logic            in_alu_zero = 1'b0;
  logic [XLEN-1:0] in_store_data = '0;
  logic [RD_W-1:0] in_rd = '0;
  logic            in_wb_en = 1'b0;
  logic            in_mem_rd = 1'b0;
  logic            in_mem_wr = 1'b0;
  logic [2:0]      in_funct3 = '0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_alu_result;
  logic            out_alu_zero;
  logic [XLEN-1:0] out_store_data;
  logic [RD_W-1:0] out_rd;
  logic            out_wb_en;
  logic            out_mem_rd;
  logic            out_mem_wr;
  logic [2:0]      out_funct3;
  logic [1:0]      occupancy;

  int checks = 0;
  int errors = 0;
  pay_t q[$];

  ex_mem_skid_reg #(.XLEN(XLEN), .RD_W(RD_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_alu_result(in_alu_result),
    .in_alu_zero(in_alu_zero), .in_store_data(in_store_data),
    .in_rd(in_rd), .in_wb_en(in_wb_en),
    .in_mem_rd(in_mem_rd), .in_mem_wr(in_mem_wr),
    .in_funct3(in_funct3),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_alu_result(out_alu_result),
    .out_alu_zero(out_alu_zero), .out_store_data(out_store_data),
    .out_rd(out_rd), .out_wb_en(out_wb_en),
    .out_mem_rd(out_mem_rd), .out_mem_wr(out_mem_wr),
    .out_funct3(out_funct3), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  function automatic pay_t in_vec();
    return {in_pc, in_alu_result, in_alu_zero, in_store_data,
            in_rd, in_wb_en, in_mem_rd, in_mem_wr, in_funct3};
  endfunction

  function automatic pay_t out_vec();
    return {out_pc, out_alu_result, out_alu_zero, out_store_data,
            out_rd, out_wb_en, out_mem_rd, out_mem_wr, out_funct3};
  endfunction

  task automatic chk(input string tag,
                     input logic [127:0] obs,
                     input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [XLEN-1:0] res,
                       input logic ordy, input logic fl);
    in_valid      = v;
    in_alu_result = res;
    in_pc         = $urandom;
    in_store_data = $urandom;
    in_alu_zero   = 1'($urandom);
    in_rd         = RD_W'($urandom);
    in_wb_en      = 1'($urandom);
    in_mem_rd     = 1'($urandom);
    in_mem_wr     = 1'($urandom);
    in_funct3     = 3'($urandom);
    out_ready     = ordy;
    flush         = fl;
  endtask

  task automatic check_model();
    chk("occupancy", 128'(occupancy), 128'(q.size()));
    chk("out_valid", 128'(out_valid), 128'(q.size() != 0));
    chk("in_ready", 128'(in_ready), 128'(q.size() < 2));
    if (q.size() != 0)
      chk("payload", 128'(out_vec()), 128'(q[0]));
  endtask

  // One clock: model follows FIFO rules with the inputs seen at the edge.
  task automatic step();
    logic acc, tk;
    @(posedge clk);
    acc = in_valid && (q.size() < 2);
    tk  = out_ready && (q.size() != 0);
    if (flush) begin
      q.delete();
    end else begin
      if (tk) void'(q.pop_front());
      if (acc) q.push_back(in_vec());
    end
    #1;
    check_model();
  endtask

  task automatic check_reset();
    chk("rst_payload", 128'(out_vec()), 128'(0));
    chk("rst_valid", 128'(out_valid), 128'(0));
    chk("rst_occ", 128'(occupancy), 128'(0));
    chk("rst_ready", 128'(in_ready), 128'(1));
  endtask

  initial begin
    logic rdy_before;

    // reset
    repeat (3) @(posedge clk);
    #1;
    check_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // single pass
    drive(1'b1, 32'h0000_1234, 1'b1, 1'b0);
    in_alu_zero = 1'b0;
    in_rd = 5'd5;
    step();
    chk("single_valid", 128'(out_valid), 128'(1));
    chk("single_res", 128'(out_alu_result), 128'h1234);
    chk("single_rd", 128'(out_rd), 128'd5);
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    step();
    chk("single_drain", 128'(occupancy), 128'(0));

    // back-pressure: A, B stored, C held by EX
    drive(1'b1, 32'hA, 1'b0, 1'b0);
    step();
    drive(1'b1, 32'hB, 1'b0, 1'b0);
    step();
    chk("bp_ready_low", 128'(in_ready), 128'(0));
    drive(1'b1, 32'hC, 1'b0, 1'b0);
    step();
    chk("bp_full", 128'(occupancy), 128'(2));
    chk("bp_hold_a", 128'(out_alu_result), 128'hA);
    out_ready = 1'b1;
    step();
    chk("bp_out_b", 128'(out_alu_result), 128'hB);
    step();
    chk("bp_out_c", 128'(out_alu_result), 128'hC);
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    step();
    chk("bp_empty", 128'(occupancy), 128'(0));

    // streaming
    for (int i = 0; i < 100; i++) begin
      drive(1'b1, 32'(i + 32'h100), 1'b1, 1'b0);
      step();
      chk("stream_occ", 128'(occupancy), 128'(1));
      chk("stream_res", 128'(out_alu_result), 128'(i + 32'h100));
    end
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    step();

    // flush while FULL with a simultaneous push of 0xDEAD
    drive(1'b1, 32'h11, 1'b0, 1'b0);
    step();
    drive(1'b1, 32'h22, 1'b0, 1'b0);
    step();
    drive(1'b1, 32'hDEAD, 1'b1, 1'b1);
    step();
    chk("flush_valid", 128'(out_valid), 128'(0));
    chk("flush_occ", 128'(occupancy), 128'(0));
    chk("flush_ready", 128'(in_ready), 128'(1));
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("flush_no_dead", 128'(out_valid), 128'(0));
    end

    // async reset while FULL and stalled
    drive(1'b1, 32'h33, 1'b0, 1'b0);
    step();
    drive(1'b1, 32'h44, 1'b0, 1'b0);
    step();
    chk("ar_full", 128'(occupancy), 128'(2));
    #2 rst_n = 1'b0;
    #1;
    check_reset();
    q.delete();
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // random traffic
    for (int i = 0; i < 12000; i++) begin
      drive(($urandom % 4) != 0, $urandom, 1'($urandom),
            ($urandom % 64) == 0);
      rdy_before = in_ready;
      out_ready = ~out_ready;
      #1;
      chk("ready_no_comb", 128'(in_ready), 128'(rdy_before));
      out_ready = ~out_ready;
      #1;
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
